// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: blank pattern, segment bit positions and a
// helper that builds a segment vector from an a..g (msb-first) pattern.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    function automatic logic [6:0] seg_pat(input logic [6:0] abcdefg);
        logic [6:0] s;
        s        = SEG_OFF;
        s[SEG_A] = abcdefg[6];
        s[SEG_B] = abcdefg[5];
        s[SEG_C] = abcdefg[4];
        s[SEG_D] = abcdefg[3];
        s[SEG_E] = abcdefg[2];
        s[SEG_F] = abcdefg[1];
        s[SEG_G] = abcdefg[0];
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD/hex to 7-segment decoder (active-high, bit 0 = segment a).
// Codes 10..15 render as the hex glyphs A, b, C, d, E, F.
module bcd_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Glyph lookup, patterns written as segments a..g
    always_comb begin
        case (bcd_i)
            4'h0:    seg_o = seg_pat(7'b111_1110);
            4'h1:    seg_o = seg_pat(7'b011_0000);
            4'h2:    seg_o = seg_pat(7'b110_1101);
            4'h3:    seg_o = seg_pat(7'b111_1001);
            4'h4:    seg_o = seg_pat(7'b011_0011);
            4'h5:    seg_o = seg_pat(7'b101_1011);
            4'h6:    seg_o = seg_pat(7'b101_1111);
            4'h7:    seg_o = seg_pat(7'b111_0000);
            4'h8:    seg_o = seg_pat(7'b111_1111);
            4'h9:    seg_o = seg_pat(7'b111_1011);
            4'hA:    seg_o = seg_pat(7'b111_0111);
            4'hB:    seg_o = seg_pat(7'b001_1111);
            4'hC:    seg_o = seg_pat(7'b100_1110);
            4'hD:    seg_o = seg_pat(7'b011_1101);
            4'hE:    seg_o = seg_pat(7'b100_1111);
            4'hF:    seg_o = seg_pat(7'b100_0111);
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed, double-buffered 7-segment scanner with leading-zero
// blanking, per-digit decimal points and PWM brightness.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter int SCAN_DIV   = 1024,
    parameter int BRIGHT_W   = 3,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIGITS*4-1:0]   digits_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    input  logic                  blank_lz_i,
    input  logic [BRIGHT_W-1:0]   brightness_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     digit_sel_o,
    output logic                  frame_o
);

    localparam int PC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PHASE_LEN = SCAN_DIV >> BRIGHT_W;
    localparam int SUB_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_LEN - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    logic [PC_W-1:0]      pc_q, pc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SUB_W-1:0]     sub_q, sub_d;
    logic [BRIGHT_W-1:0]  phase_q, phase_d;
    logic [BRIGHT_W-1:0]  bri_q;
    logic [DIGITS*4-1:0]  shadow_dig_q, disp_dig_q;
    logic [DIGITS-1:0]    shadow_dp_q, disp_dp_q;
    logic                 disp_valid_q;
    logic [6:0]           seg_q;
    logic                 dp_q;
    logic [DIGITS-1:0]    sel_q;
    logic                 frame_q;

    logic                 pc_wrap_s, frame_end_s, frame_d;
    logic [BRIGHT_W-1:0]  bri_s;
    logic                 lit_s;
    logic [DIGITS-1:0]    blank_mask_s, sel_s;
    logic [3:0]           cur_bcd_s;
    logic                 cur_dp_s, cur_blank_s;
    logic [6:0]           dec_seg_s, seg_s;
    logic                 dp_s;

    // Prescaler, slot index and PWM phase sequencing
    always_comb begin
        pc_wrap_s   = (pc_q == PC_LAST);
        frame_end_s = pc_wrap_s && (idx_q == IDX_LAST);
        if (pc_wrap_s) begin
            pc_d    = {PC_W{1'b0}};
            sub_d   = {SUB_W{1'b0}};
            phase_d = {BRIGHT_W{1'b0}};
            idx_d   = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
        end else begin
            pc_d    = pc_q + PC_W'(1);
            idx_d   = idx_q;
            sub_d   = (sub_q == SUB_LAST) ? {SUB_W{1'b0}} : sub_q + SUB_W'(1);
            phase_d = (sub_q == SUB_LAST) ? phase_q + BRIGHT_W'(1) : phase_q;
        end
        frame_d = (pc_d == PC_LAST) && (idx_d == IDX_LAST);
        // the slot's first cycle already uses the freshly sampled brightness
        bri_s   = (pc_q == {PC_W{1'b0}}) ? brightness_i : bri_q;
        lit_s   = disp_valid_q && (phase_q < bri_s);
    end

    // Leading-zero mask: digit k blanks when it and every digit above are zero
    always_comb begin
        logic all_zero;
        all_zero     = 1'b1;
        blank_mask_s = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k > 0; k--) begin
            all_zero        = all_zero && (disp_dig_q[k*4 +: 4] == 4'd0);
            blank_mask_s[k] = blank_lz_i && all_zero;
        end
    end

    // Select the scanned digit's code, dp and blank flag; build the one-hot enable
    always_comb begin
        cur_bcd_s   = 4'd0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        sel_s       = {DIGITS{1'b0}};
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IDX_W'(d)) begin
                cur_bcd_s   = disp_dig_q[d*4 +: 4];
                cur_dp_s    = disp_dp_q[d];
                cur_blank_s = blank_mask_s[d];
                sel_s[d]    = lit_s;
            end else begin
                sel_s[d]    = 1'b0;
            end
        end
    end

    bcd_to_seven_seg u_dec (
        .bcd_i (cur_bcd_s),
        .seg_o (dec_seg_s)
    );

    // Gate segments and dp with the PWM window and blanking
    always_comb begin
        if (lit_s && !cur_blank_s) begin
            seg_s = dec_seg_s;
        end else begin
            seg_s = SEG_OFF;
        end
        dp_s = lit_s && cur_dp_s;
    end

    // Counters, buffers and the polarity-adjusted output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= {PC_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            sub_q        <= {SUB_W{1'b0}};
            phase_q      <= {BRIGHT_W{1'b0}};
            bri_q        <= {BRIGHT_W{1'b0}};
            shadow_dig_q <= {(DIGITS*4){1'b0}};
            shadow_dp_q  <= {DIGITS{1'b0}};
            disp_dig_q   <= {(DIGITS*4){1'b0}};
            disp_dp_q    <= {DIGITS{1'b0}};
            disp_valid_q <= 1'b0;
            seg_q        <= SEG_OFF ^ {7{POL}};
            dp_q         <= POL;
            sel_q        <= {DIGITS{POL}};
            frame_q      <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            bri_q   <= bri_s;
            if (load_i) begin
                shadow_dig_q <= digits_i;
                shadow_dp_q  <= dp_i;
            end
            // a load on the boundary cycle bypasses the shadow so it shows immediately
            if (frame_end_s) begin
                disp_valid_q <= 1'b1;
                disp_dig_q   <= load_i ? digits_i : shadow_dig_q;
                disp_dp_q    <= load_i ? dp_i : shadow_dp_q;
            end
            seg_q   <= seg_s ^ {7{POL}};
            dp_q    <= dp_s ^ POL;
            sel_q   <= sel_s ^ {DIGITS{POL}};
            frame_q <= frame_d;
        end
    end

    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign digit_sel_o = sel_q;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: cycle-count based reference model checked every
// cycle on an active-high and an active-low instance, plus directed frame checks.
module tb_seven_seg_scanner;

    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 16;
    localparam int BRIGHT_W = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DIGITS*4-1:0]  digits;
    logic [DIGITS-1:0]    dp;
    logic                 load, blank;
    logic [BRIGHT_W-1:0]  bri;
    logic [6:0]           seg_h, seg_l;
    logic                 dp_h, dp_l, frame_h, frame_l;
    logic [DIGITS-1:0]    sel_h, sel_l;

    always #5 clk = ~clk;

    seven_seg_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W), .ACTIVE_LOW(0)) dut (
        .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp), .load_i(load),
        .blank_lz_i(blank), .brightness_i(bri), .seg_o(seg_h), .dp_o(dp_h),
        .digit_sel_o(sel_h), .frame_o(frame_h));

    seven_seg_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W), .ACTIVE_LOW(1)) dut_al (
        .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp), .load_i(load),
        .blank_lz_i(blank), .brightness_i(bri), .seg_o(seg_l), .dp_o(dp_l),
        .digit_sel_o(sel_l), .frame_o(frame_l));

    int n_vec = 0;
    int n_fail = 0;

    logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: m_t counts cycles since reset release
    int          m_t;
    logic [3:0]  m_sh [DIGITS];
    logic [3:0]  m_dy [DIGITS];
    logic        m_shdp [DIGITS];
    logic        m_dydp [DIGITS];
    logic        m_valid;
    int          m_bri;
    bit          m_init = 1'b0;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;
    logic [DIGITS-1:0] e_sel;

    task automatic model_step();
        int pc, idx, phase, bnow;
        bit lit, blk;
        if (rst) begin
            m_t = 0; m_valid = 1'b0; m_bri = 0;
            for (int d = 0; d < DIGITS; d++) begin
                m_sh[d] = 4'd0; m_dy[d] = 4'd0; m_shdp[d] = 1'b0; m_dydp[d] = 1'b0;
            end
            e_seg = 7'h00; e_dp = 1'b0; e_sel = '0; e_frame = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            pc    = m_t % SCAN_DIV;
            idx   = (m_t / SCAN_DIV) % DIGITS;
            bnow  = (pc == 0) ? int'(bri) : m_bri;
            phase = pc / (SCAN_DIV >> BRIGHT_W);
            lit   = m_valid && (phase < bnow);
            blk   = 1'b0;
            if (blank && idx > 0) begin
                blk = 1'b1;
                for (int k = idx; k < DIGITS; k++) if (m_dy[k] != 4'd0) blk = 1'b0;
            end
            e_sel = lit ? DIGITS'(1 << idx) : '0;
            e_seg = (lit && !blk) ? dec_tbl[m_dy[idx]] : 7'h00;
            e_dp  = lit && m_dydp[idx];
            if (pc == SCAN_DIV - 1 && idx == DIGITS - 1) begin
                m_valid = 1'b1;
                for (int d = 0; d < DIGITS; d++) begin
                    m_dy[d]   = load ? digits[d*4 +: 4] : m_sh[d];
                    m_dydp[d] = load ? dp[d] : m_shdp[d];
                end
            end
            if (load) begin
                for (int d = 0; d < DIGITS; d++) begin
                    m_sh[d] = digits[d*4 +: 4]; m_shdp[d] = dp[d];
                end
            end
            m_bri   = bnow;
            m_t     = m_t + 1;
            e_frame = ((m_t % FRAME) == FRAME - 1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            n_vec++;
            if ({seg_h, dp_h, sel_h, frame_h} !== {e_seg, e_dp, e_sel, e_frame}) begin
                n_fail++;
                $display("FAIL cyc_hi t=%0d: seg=%h dp=%b sel=%b frm=%b, expected seg=%h dp=%b sel=%b frm=%b",
                         m_t, seg_h, dp_h, sel_h, frame_h, e_seg, e_dp, e_sel, e_frame);
            end
            n_vec++;
            if ({seg_l, dp_l, sel_l, frame_l} !== {~e_seg, ~e_dp, ~e_sel, e_frame}) begin
                n_fail++;
                $display("FAIL cyc_lo t=%0d: seg=%h dp=%b sel=%b frm=%b, expected seg=%h dp=%b sel=%b frm=%b",
                         m_t, seg_l, dp_l, sel_l, frame_l, ~e_seg, ~e_dp, ~e_sel, e_frame);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Frame statistics gathered from the active-high instance
    int         cnt [DIGITS];
    logic [6:0] segor [DIGITS];
    int         dpcnt [DIGITS];
    int         frames, bad_sel, lit_total, stray_dp;

    task automatic run_frame(input int load_at, input logic [DIGITS*4-1:0] val, input logic [DIGITS-1:0] dpv);
        for (int d = 0; d < DIGITS; d++) begin cnt[d] = 0; segor[d] = 7'h00; dpcnt[d] = 0; end
        frames = 0; bad_sel = 0; lit_total = 0; stray_dp = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (frame_h) frames++;
            if (!$onehot0(sel_h)) bad_sel++;
            if (sel_h != '0) lit_total++;
            if (dp_h && sel_h == '0) stray_dp++;
            for (int d = 0; d < DIGITS; d++) begin
                if (sel_h == DIGITS'(1 << d)) begin
                    cnt[d]++; segor[d] = segor[d] | seg_h;
                    if (dp_h) dpcnt[d]++;
                end
            end
            load = (i == load_at);
            if (i == load_at) begin digits = val; dp = dpv; end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic sync_frame(output int lit);
        int guard;
        guard = 0; lit = 0;
        while ((m_t % FRAME) != 0 && guard < 3 * FRAME) begin
            if (sel_h != '0) lit++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 3 * FRAME) begin
            n_vec++; n_fail++;
            $display("FAIL sync_timeout: got %0d cycles, expected < %0d", guard, 3 * FRAME);
        end
    endtask

    initial begin
        int lit;
        rst = 1'b1; load = 1'b0; blank = 1'b0; bri = '0; digits = '0; dp = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg", int'(seg_h), 0);
        chk("rst_sel", int'(sel_h), 0);
        chk("rst_dp_frame", int'({dp_h, frame_h}), 0);
        chk("rst_al_seg", int'(seg_l), 'h7F);
        chk("rst_al_sel", int'(sel_l), 'h3F);
        rst = 1'b0;

        // frame 0: load 123456 mid-frame; display must stay dark
        bri = 2'd3; digits = 24'h123456; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sync_frame(lit);
        chk("first_frame_dark", lit, 0);

        // frame 1: full scan of 123456
        run_frame(-1, '0, '0);
        for (int d = 0; d < DIGITS; d++) chk($sformatf("slot_lit_%0d", d), cnt[d], 12);
        chk("digit0_is_6", int'(segor[0]), 'h7D);
        chk("digit5_is_1", int'(segor[5]), 'h06);
        chk("frame_pulses", frames, 1);
        chk("onehot", bad_sel, 0);

        // frame 2: mid-frame load of 999999 must not tear
        run_frame(40, 24'h999999, '0);
        chk("tear_d5_old", int'(segor[5]), 'h06);
        chk("tear_d0_old", int'(segor[0]), 'h7D);

        // frame 3: shows 999999; load 123456 on the boundary cycle
        run_frame(FRAME - 1, 24'h123456, '0);
        chk("new_d5", int'(segor[5]), 'h6F);
        chk("new_d0", int'(segor[0]), 'h6F);

        // frame 4: boundary load visible at once; queue 000070
        run_frame(10, 24'h000070, '0);
        chk("bnd_d0", int'(segor[0]), 'h7D);
        chk("bnd_d3", int'(segor[3]), 'h4F);

        // frame 5: leading-zero blanking of 000070; queue 000000
        blank = 1'b1;
        run_frame(10, 24'h000000, '0);
        chk("blank_hi", int'(segor[5] | segor[4] | segor[3] | segor[2]), 0);
        chk("blank_d1", int'(segor[1]), 'h07);
        chk("blank_d0", int'(segor[0]), 'h3F);
        chk("blank_sel_d5", cnt[5], 12);

        // frame 6: all zero shows only digit 0; queue 123456 with dp on digit 2
        run_frame(10, 24'h123456, 6'b000100);
        chk("zero_d0", int'(segor[0]), 'h3F);
        chk("zero_rest", int'(segor[5] | segor[4] | segor[3] | segor[2] | segor[1]), 0);

        // frame 7: brightness 0 is dark
        blank = 1'b0; bri = 2'd0;
        run_frame(-1, '0, '0);
        chk("bri0_dark", lit_total, 0);

        // frame 8: brightness 1 lights 4 of 16 cycles
        bri = 2'd1;
        run_frame(-1, '0, '0);
        chk("bri1_d0", cnt[0], 4);
        chk("bri1_d4", cnt[4], 4);

        // frame 9: dp only on digit 2
        bri = 2'd3;
        run_frame(-1, '0, '0);
        for (int d = 0; d < DIGITS; d++) chk($sformatf("dp_%0d", d), dpcnt[d], (d == 2) ? 12 : 0);
        chk("dp_stray", stray_dp, 0);

        // random phase: loads, blanking, brightness, occasional reset
        for (int i = 0; i < 4000; i++) begin
            load = ($urandom_range(0, 39) == 0);
            if (load) begin
                for (int d = 0; d < DIGITS; d++) digits[d*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                dp = DIGITS'($urandom);
            end
            if ($urandom_range(0, 99) == 0) blank = ~blank;
            if ($urandom_range(0, 19) == 0) bri = BRIGHT_W'($urandom);
            rst = ($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
